fake_rom_bus: RTL and testbench

//  Parametrised simulation/FPGA instruction ROM for the CPU fetch path; replaces the bare fake ROM.

---
 rtl/fake_rom_bus.sv | 126 ++++++++++++
 tb/tb_fake_rom_bus.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fake_rom_bus.sv
// Instruction ROM behind a req/ack bus with programmable wait states.
// Define FAKE_ROM_BUS_ERR_EN to enable the address range check and bus error response.
module fake_rom_bus #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 10,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1FC0_0000,
    parameter string                 INIT_FILE   = "rom.hex"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int OFF   = $clog2(DATA_WIDTH / 8);
    localparam int WORDS = 2 ** DEPTH_LOG2;
    localparam logic [7:0] LP_CNT_INIT =
        8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] LP_ERR_WORD =
        DATA_WIDTH'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_cnt;
    logic [7:0]              w_cnt_next;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_oor;
    logic                    r_ack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    w_capture;
    logic                    w_oor;
    logic                    w_unused_addr;
    logic [DATA_WIDTH-1:0]   r_mem [0:WORDS-1];

    initial begin
        if (WAIT_CYCLES > 255 || WAIT_CYCLES < 0)
            $error("fake_rom_bus: WAIT_CYCLES out of range 0..255");
        for (int i = 0; i < WORDS; i++)
            r_mem[i] = '0;
    end

`ifdef FAKE_ROM_BUS_ERR_EN
    // One extra bit so BASE_ADDR + size cannot wrap at the top of the map.
    localparam logic [ADDR_WIDTH:0] LP_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LP_HI =
        LP_LO + (ADDR_WIDTH + 1)'(WORDS * (DATA_WIDTH / 8));

    assign w_oor = ({1'b0, addr} < LP_LO) || ({1'b0, addr} >= LP_HI);
`else
    assign w_oor = 1'b0;
`endif

    assign w_unused_addr = ^addr;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_capture = 1'b1;
                    if (w_oor || WAIT_CYCLES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LP_CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req)
                    w_next = S_IDLE;
                else if (r_cnt == 8'd0)
                    w_next = S_RESP;
                else
                    w_cnt_next = r_cnt - 8'd1;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ack   <= (r_state == S_RESP);
            if (w_capture) begin
                r_idx <= addr[OFF+DEPTH_LOG2-1:OFF];
                r_oor <= w_oor;
            end
            if (r_state == S_RESP) begin
                r_rdata <= r_oor ? LP_ERR_WORD : r_mem[r_idx];
                r_err   <= r_oor;
            end
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_fake_rom_bus.sv
// Scoreboard bench for fake_rom_bus with WAIT_CYCLES = 2, 0 and 3.
// Honours FAKE_ROM_BUS_ERR_EN when choosing out-of-range expectations.
module tb_fake_rom_bus;

    localparam logic [31:0] BASE = 32'h1FC0_0000;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          dut;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        busy  [3];

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
        fake_rom_bus #(
            .WAIT_CYCLES(W),
            .INIT_FILE  ("")
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req  (req[g]),
            .addr (addr[g]),
            .ack  (ack[g]),
            .rdata(rdata[g]),
            .err  (err[g]),
            .busy (busy[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(int i);
        logic [31:0] w;
        w = (i == 0) ? 32'h3C08_BFC0 : (32'hA000_0000 | 32'(i));
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (ack[g] === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexp_ack", {31'b0, ack[g]}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_dut", 32'(g), 32'(e.dut));
                    chk("rdata", rdata[g], e.d);
                    chk("err", {31'b0, err[g]}, {31'b0, e.e});
                end
            end
        end
    end

    task automatic push(int g, logic [31:0] ed, logic ee);
        exp_t e;
        e.d   = ed;
        e.e   = ee;
        e.dut = g;
        q.push_back(e);
    endtask

    task automatic rd(int g, logic [31:0] a, logic [31:0] ed,
                      logic ee, int lat);
        int k;
        push(g, ed, ee);
        req[g]  = 1'b1;
        addr[g] = a;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end while (ack[g] !== 1'b1 && k < 50);
        chk("latency", 32'(k), 32'(lat));
        req[g] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            req[g]  = 1'b0;
            addr[g] = BASE;
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            g_dut[0].u_dut.r_mem[i] = word(i);
            g_dut[1].u_dut.r_mem[i] = word(i);
            g_dut[2].u_dut.r_mem[i] = word(i);
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_ack", {31'b0, ack[g]}, 32'd0);
            chk("rst_rdata", rdata[g], 32'd0);
            chk("rst_err", {31'b0, err[g]}, 32'd0);
            chk("rst_busy", {31'b0, busy[g]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        rd(0, BASE, 32'h3C08_BFC0, 1'b0, 4);
        rd(0, BASE + 32'd9, word(2), 1'b0, 4);
`ifdef FAKE_ROM_BUS_ERR_EN
        rd(0, BASE + 32'd4096, 32'hDEAD_BEEF, 1'b1, 2);
        rd(0, BASE - 32'd4, 32'hDEAD_BEEF, 1'b1, 2);
`else
        rd(0, BASE + 32'd4096, word(0), 1'b0, 4);
`endif
        rd(0, BASE + 32'd4, word(1), 1'b0, 4);

        for (int w = 0; w < 4; w++)
            push(1, word(w), 1'b0);
        req[1]  = 1'b1;
        addr[1] = BASE;
        for (int w = 0; w < 4; w++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_busy_hi", {31'b0, busy[1]}, 32'd1);
            chk("b2b_ack_lo", {31'b0, ack[1]}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_busy_lo", {31'b0, busy[1]}, 32'd0);
            chk("b2b_ack_hi", {31'b0, ack[1]}, 32'd1);
            addr[1] = BASE + 32'(4 * (w + 1));
        end
        req[1] = 1'b0;
        @(negedge clk);
        rd(1, BASE + 32'd12, word(3), 1'b0, 2);

        rd(2, BASE + 32'd4, word(1), 1'b0, 5);
        req[2]  = 1'b1;
        addr[2] = BASE + 32'd8;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_hi", {31'b0, busy[2]}, 32'd1);
        req[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_idle", {31'b0, busy[2]}, 32'd0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_ack", {31'b0, ack[2]}, 32'd0);
        end
        chk("abort_rdata", rdata[2], word(1));

        req[2]  = 1'b1;
        addr[2] = BASE + 32'd12;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ack", {31'b0, ack[2]}, 32'd0);
        chk("arst_rdata", rdata[2], 32'd0);
        chk("arst_busy", {31'b0, busy[2]}, 32'd0);
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(2, BASE + 32'd12, word(3), 1'b0, 5);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
